// File: rtl/geiger_pkg.sv
// geiger_pkg
// Shared definitions for the multi-channel geiger event stack: record geometry,
// byte0 field layout, drop-counter width, serializer state type and a helper
// that assembles a 56-bit event record.
package geiger_pkg;

    localparam int GEIG_REC_W = 56;
    localparam int GEIG_TS_W  = 48;
    localparam int GEIG_BYTES = 7;
    localparam int DROP_CNT_W = 16;

    // byte0 = {ovf, 4'b0, ch[2:0]}
    localparam int B0_OVF_BIT = 7;
    localparam int B0_CH_LSB  = 0;
    localparam int B0_CH_W    = 3;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    function automatic logic [GEIG_REC_W-1:0] geig_pack_rec(
        input logic                 ovf,
        input logic [B0_CH_W-1:0]   ch,
        input logic [GEIG_TS_W-1:0] ts
    );
        logic [7:0] b0;
        b0 = '0;
        b0[B0_OVF_BIT] = ovf;
        b0[B0_CH_LSB +: B0_CH_W] = ch;
        return {b0, ts};
    endfunction

endpackage

// File: rtl/geiger_rec_serializer.sv
// geiger_rec_serializer
// Turns one 56-bit event record into seven bytes, MSB first, on a valid/ack bus.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_load      load i_rec (only issued while idle)
//   i_rec       record to send
//   i_ack       byte ack, only meaningful while o_valid=1
//   o_ready     may accept a record on the following cycle
//   o_data      current byte
//   o_valid     o_data holds a valid byte
module geiger_rec_serializer
    import geiger_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [GEIG_REC_W-1:0] i_rec,
    input  logic                  i_ack,
    output logic                  o_ready,
    output logic [7:0]            o_data,
    output logic                  o_valid
);

    ser_state_t            r_state;
    logic [GEIG_REC_W-1:0] r_shift;
    logic [2:0]            r_idx;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  w_ack;
    logic                  w_last;

    assign w_ack  = (r_state == SER_SEND) && i_ack;
    assign w_last = (r_idx == 3'(GEIG_BYTES - 1));

    // Ready already during the cycle the final byte is acked, so the owner can
    // fetch the next record in parallel and the bus idles for a single cycle.
    assign o_ready = (r_state == SER_IDLE) || (w_ack && w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SER_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                SER_IDLE: begin
                    if (i_load) begin
                        r_shift <= i_rec;
                        r_data  <= i_rec[GEIG_REC_W-1 -: 8];
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_state <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (w_ack) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_state <= SER_IDLE;
                        end else begin
                            // r_shift keeps the current byte at the top
                            r_shift <= {r_shift[GEIG_REC_W-9:0], 8'h00};
                            r_data  <= r_shift[GEIG_REC_W-9 -: 8];
                            r_idx   <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= SER_IDLE;
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/geiger_event_stack_mc.sv
// geiger_event_stack_mc
// Detects pulses on NUM_CH geiger tube inputs, timestamps each accepted pulse,
// buffers records in a DEPTH-deep FIFO and streams them out as bytes.
// Ports:
//   CLK_1MHZ    system clock
//   RESET       asynchronous active-low reset
//   GEIG_IN     raw tube pulses (asynchronous)
//   TIME_STAMP  mission time, CLK_1MHZ domain
//   RD_EN       byte ack, sampled while D_VALID=1
//   D_OUT       current record byte
//   D_VALID     D_OUT holds a valid byte
//   EMPTY/FULL  registered FIFO status
//   DROP_CNT    saturating count of events lost to a full FIFO
module geiger_event_stack_mc
    import geiger_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 16,
    parameter int DEAD_CYC = 8,
    parameter int TS_W     = 48
) (
    input  logic                  CLK_1MHZ,
    input  logic                  RESET,
    input  logic [NUM_CH-1:0]     GEIG_IN,
    input  logic [TS_W-1:0]       TIME_STAMP,
    input  logic                  RD_EN,
    output logic [7:0]            D_OUT,
    output logic                  D_VALID,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [DROP_CNT_W-1:0] DROP_CNT
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int DT_W = $clog2(DEAD_CYC + 1);

    // Input synchronisers; r_sync3 is the previous synchronised value for edge detect
    logic [NUM_CH-1:0] r_sync1, r_sync2, r_sync3;
    logic [NUM_CH-1:0] w_accept;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH*TS_W-1:0] w_ts_flat;

    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= GEIG_IN;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DT_W-1:0] r_dead;
        logic [TS_W-1:0] r_ts;

        assign w_accept[gi] = r_sync2[gi] && !r_sync3[gi] && (r_dead == '0);
        assign w_ts_flat[gi*TS_W +: TS_W] = r_ts;

        always_ff @(posedge CLK_1MHZ or negedge RESET) begin
            if (!RESET) begin
                r_dead <= '0;
                r_ts   <= '0;
            end else if (w_accept[gi]) begin
                r_dead <= DT_W'(DEAD_CYC);
                r_ts   <= TIME_STAMP;
            end else if (r_dead != '0) begin
                r_dead <= r_dead - 1'b1;
            end
        end
    end

    // Fixed-priority arbiter: lowest-index pending channel wins
    logic            w_any;
    logic [2:0]      w_sel;
    logic [TS_W-1:0] w_sel_ts;

    always_comb begin
        w_any    = 1'b0;
        w_sel    = '0;
        w_sel_ts = '0;
        w_clr    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_any    = 1'b1;
                w_sel    = 3'(i);
                w_sel_ts = w_ts_flat[i*TS_W +: TS_W];
                w_clr    = '0;
                w_clr[i] = 1'b1;
            end
        end
    end

    logic                  r_full, r_empty, r_ovf;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  w_push, w_drop, w_pop, w_ser_ready;
    logic [GEIG_REC_W-1:0] w_rec;

    // Admission uses the registered FULL; a same-cycle pop does not free a slot
    assign w_push = w_any && !r_full;
    assign w_drop = w_any && r_full;
    assign w_rec  = geig_pack_rec(r_ovf, w_sel, w_sel_ts);

    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            r_pending  <= '0;
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_accept;
            if (w_drop) begin
                if (r_drop_cnt != {DROP_CNT_W{1'b1}})
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                r_ovf <= 1'b1;
            end else if (w_push) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FIFO: one extra pointer bit distinguishes full from empty
    logic [GEIG_REC_W-1:0] r_mem [DEPTH];
    logic [GEIG_REC_W-1:0] r_rd_data;
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [PW-1:0]         w_wr_next, w_rd_next;
    logic                  r_pop_dly;

    // r_pop_dly blocks a second pop while the first read is still in flight
    assign w_pop     = !r_empty && w_ser_ready && !r_pop_dly;
    assign w_wr_next = r_wr_ptr + PW'(w_push);
    assign w_rd_next = r_rd_ptr + PW'(w_pop);

    always_ff @(posedge CLK_1MHZ) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
        if (w_pop)
            r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_pop_dly <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_next;
            r_rd_ptr  <= w_rd_next;
            r_empty   <= (w_wr_next == w_rd_next);
            r_full    <= (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]) &&
                         (w_wr_next[AW] != w_rd_next[AW]);
            r_pop_dly <= w_pop;
        end
    end

    geiger_rec_serializer u_ser (
        .clk     (CLK_1MHZ),
        .rst_n   (RESET),
        .i_load  (r_pop_dly),
        .i_rec   (r_rd_data),
        .i_ack   (RD_EN),
        .o_ready (w_ser_ready),
        .o_data  (D_OUT),
        .o_valid (D_VALID)
    );

    assign EMPTY    = r_empty;
    assign FULL     = r_full;
    assign DROP_CNT = r_drop_cnt;

endmodule

// File: tb/tb_geiger_event_stack_mc.sv
// Directed bench for geiger_event_stack_mc with a record scoreboard.
module tb_geiger_event_stack_mc;

    localparam int NUM_CH   = 4;
    localparam int DEPTH    = 16;
    localparam int DEAD_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  geig_in = '0;
    logic [47:0] time_stamp = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  d_out;
    logic        d_valid, empty, full;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    geiger_event_stack_mc #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DEAD_CYC(DEAD_CYC), .TS_W(48)
    ) u_dut (
        .CLK_1MHZ   (clk),
        .RESET      (rst_n),
        .GEIG_IN    (geig_in),
        .TIME_STAMP (time_stamp),
        .RD_EN      (rd_en),
        .D_OUT      (d_out),
        .D_VALID    (d_valid),
        .EMPTY      (empty),
        .FULL       (full),
        .DROP_CNT   (drop_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [55:0] sb_q[$];
    int          m_held  = 0;  // records inside DUT (FIFO + serializer)
    logic        m_ovf   = 1'b0;
    int          m_drops = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model one accepted event; a stalled DUT holds DEPTH records plus one in the serializer
    task automatic model_event(input int ch, input logic [47:0] ts);
        logic [2:0] c3;
        c3 = 3'(ch);
        if (m_held >= DEPTH + 1) begin
            m_drops++;
            m_ovf = 1'b1;
        end else begin
            sb_q.push_back({m_ovf, 4'b0000, c3, ts});
            m_ovf = 1'b0;
            m_held++;
        end
    endtask

    task automatic inject(input logic [3:0] mask, input logic [47:0] ts);
        rd_en      = 1'b0;
        time_stamp = ts;
        geig_in    = mask;
        for (int c = 0; c < NUM_CH; c++)
            if (mask[c]) model_event(c, ts);
        repeat (3) tick();
        geig_in = '0;
        repeat (9) tick();
        $display("inject mask=%b ts=%012h drops_model=%0d", mask, ts, m_drops);
    endtask

    // Receive one full record with RD_EN high; waited = idle cycles before D_VALID
    task automatic recv_rec(input int max_wait, output int waited, output logic [7:0] b0_obs);
        logic [55:0] exp;
        logic        got;
        rd_en  = 1'b1;
        got    = 1'b0;
        waited = 0;
        b0_obs = '0;
        while (!got && waited < max_wait) begin
            if (d_valid) got = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        if (d_valid) got = 1'b1;
        check("dvalid_wait", got, 1'b1);
        check("sb_nonempty", 64'(sb_q.size() > 0), 1);
        if (!got || sb_q.size() == 0) return;
        exp    = sb_q.pop_front();
        b0_obs = d_out;
        for (int b = 0; b < 7; b++) begin
            check($sformatf("dvalid_b%0d", b), d_valid, 1'b1);
            check($sformatf("byte%0d", b), d_out, exp[55-8*b -: 8]);
            tick();
        end
        check("gap_dvalid", d_valid, 1'b0);
        m_held--;
        $display("record exp=%014h b0=%02h waited=%0d", exp, b0_obs, waited);
    endtask

    initial begin
        int          w;
        int          lat;
        logic        got;
        logic        seen;
        logic [7:0]  b0;
        logic [55:0] exp;

        // 1: reset
        rst_n = 1'b0;
        repeat (10) tick();
        rst_n = 1'b1;
        tick();
        check("rst_empty", empty, 1'b1);
        check("rst_dvalid", d_valid, 1'b0);
        check("rst_dropcnt", drop_cnt, 16'd0);
        check("rst_full", full, 1'b0);
        check("rst_dout", d_out, 8'h00);

        // 2: single event on ch2, latency and bytes
        time_stamp = 48'h0000_009B_9E10;
        model_event(2, time_stamp);
        rd_en   = 1'b1;
        geig_in = 4'b0100;
        lat     = 0;
        got     = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (lat == 3) geig_in = '0;
            if (d_valid) got = 1'b1;
        end
        check("latency", lat, 6);
        recv_rec(5, w, b0);
        check("t2_byte0", b0, 8'h02);
        check("t2_empty", empty, 1'b1);

        // 3: four simultaneous events come out in channel order, back to back
        inject(4'b1111, 48'h1234_5678_9ABC);
        for (int r = 0; r < 4; r++) begin
            recv_rec(10, w, b0);
            check($sformatf("t3_ch%0d", r), b0, 8'(r));
            if (r > 0) check("t3_gap_cycles", w, 1);
        end

        // 4: second pulse inside dead time is ignored
        rd_en      = 1'b0;
        time_stamp = 48'h0000_0000_4444;
        model_event(1, time_stamp);
        geig_in = 4'b0010; tick();
        geig_in = 4'b0000; tick(); tick();
        geig_in = 4'b0010; tick();
        geig_in = 4'b0000;
        repeat (12) tick();
        recv_rec(10, w, b0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (d_valid) seen = 1'b1;
        end
        check("t4_single_record", seen, 1'b0);
        check("t4_dropcnt", drop_cnt, 16'd0);
        check("t4_empty", empty, 1'b1);

        // 5: overflow. The stalled serializer absorbs one record first.
        inject(4'b0001, 48'h0000_0000_0100);
        for (int k = 0; k < DEPTH + 3; k++)
            inject(4'(1 << (k % 4)), 48'h0000_0000_0200 + 48'(k));
        check("t5_full", full, 1'b1);
        check("t5_dropcnt", drop_cnt, 16'd3);
        exp = sb_q[0];
        repeat (3) tick();
        check("t5_hold_dvalid", d_valid, 1'b1);
        check("t5_hold_dout", d_out, exp[55:48]);
        recv_rec(2, w, b0);
        rd_en = 1'b0;
        check("t5_not_full", full, 1'b0);
        inject(4'b1000, 48'h0000_0000_0ABC);
        while (sb_q.size() > 0)
            recv_rec(40, w, b0);
        check("t5_ovf_bit", b0[7], 1'b1);
        check("t5_ovf_ch", b0[2:0], 3'd3);
        check("t5_empty", empty, 1'b1);

        // 6: reset in the middle of a record
        inject(4'b0100, 48'h0000_1111_2222);
        exp   = sb_q[0];
        rd_en = 1'b1;
        tick(); tick(); tick();
        check("t6_b3_valid", d_valid, 1'b1);
        check("t6_b3", d_out, exp[31:24]);
        rst_n = 1'b0;
        #1;
        check("t6_rst_dvalid", d_valid, 1'b0);
        check("t6_rst_empty", empty, 1'b1);
        check("t6_rst_dropcnt", drop_cnt, 16'd0);
        tick();
        check("t6_rst_dvalid_next", d_valid, 1'b0);
        rst_n = 1'b1;
        sb_q.delete();
        m_held = 0;
        m_ovf  = 1'b0;
        tick();

        // Post-reset record carries no stale overflow flag
        inject(4'b0001, 48'h0000_0000_7777);
        recv_rec(10, w, b0);
        check("t6_post_b0", b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
